// File: rtl/pc_stack.sv
// Program counter with a return-address stack for call/return.
// Ports: clk, reset (async, active-high), stall, op[2:0], Branchaddr,
//        PCout, depth, ovf/unf (sticky overflow/underflow flags).
module pc_stack #(
    parameter int Psize  = 6,
    parameter int Sdepth = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    input  logic [2:0]                   op,
    input  logic [Psize-1:0]             Branchaddr,
    output logic [Psize-1:0]             PCout,
    output logic [$clog2(Sdepth+1)-1:0]  depth,
    output logic                         ovf,
    output logic                         unf
);

    localparam int DW = $clog2(Sdepth + 1);

    localparam logic [2:0] OP_INC  = 3'b001;
    localparam logic [2:0] OP_REL  = 3'b010;
    localparam logic [2:0] OP_JMP  = 3'b011;
    localparam logic [2:0] OP_CALL = 3'b100;
    localparam logic [2:0] OP_RET  = 3'b101;

    logic [Psize-1:0] r_pc;
    logic [DW-1:0]    r_depth;
    logic             r_ovf;
    logic             r_unf;
    logic [Psize-1:0] r_stack [Sdepth];

    logic             w_full;
    logic             w_empty;
    logic [Psize-1:0] w_addend;
    logic [Psize-1:0] w_sum;
    logic [Psize-1:0] w_top;
    logic [Psize-1:0] w_pc_nxt;
    logic [DW-1:0]    w_depth_nxt;
    logic             w_ovf_nxt;
    logic             w_unf_nxt;
    logic             w_push;

    assign w_full  = (r_depth == DW'(Sdepth));
    assign w_empty = (r_depth == '0);

    // One adder serves increment, relative branch and the call return
    // address: the offset is zeroed for everything but a relative branch,
    // and the +1 is the carry-in. Sign extension is implicit modulo 2^Psize.
    assign w_addend = (op == OP_REL) ? Branchaddr : '0;
    assign w_sum    = r_pc + w_addend + Psize'(1);

    always_comb begin
        w_top = '0;
        for (int i = 0; i < Sdepth; i++) begin
            if (r_depth == DW'(i + 1)) begin
                w_top = r_stack[i];
            end
        end
    end

    always_comb begin
        w_pc_nxt    = r_pc;
        w_depth_nxt = r_depth;
        w_ovf_nxt   = r_ovf;
        w_unf_nxt   = r_unf;
        w_push      = 1'b0;
        if (!stall) begin
            case (op)
                OP_INC, OP_REL: begin
                    w_pc_nxt = w_sum;
                end
                OP_JMP: begin
                    w_pc_nxt = Branchaddr;
                end
                OP_CALL: begin
                    if (w_full) begin
                        w_pc_nxt  = w_sum;
                        w_ovf_nxt = 1'b1;
                    end else begin
                        w_push      = 1'b1;
                        w_depth_nxt = r_depth + DW'(1);
                        w_pc_nxt    = Branchaddr;
                    end
                end
                OP_RET: begin
                    if (w_empty) begin
                        w_pc_nxt  = w_sum;
                        w_unf_nxt = 1'b1;
                    end else begin
                        w_depth_nxt = r_depth - DW'(1);
                        w_pc_nxt    = w_top;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc    <= '0;
            r_depth <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_pc    <= w_pc_nxt;
            r_depth <= w_depth_nxt;
            r_ovf   <= w_ovf_nxt;
            r_unf   <= w_unf_nxt;
        end
    end

    // Storage is not reset; entries at or above depth are never read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < Sdepth; i++) begin
            if (w_push && !reset && r_depth == DW'(i)) begin
                r_stack[i] <= w_sum;
            end
        end
    end

    assign PCout = r_pc;
    assign depth = r_depth;
    assign ovf   = r_ovf;
    assign unf   = r_unf;

endmodule

// File: tb/tb_pc_stack.sv
// Scoreboard bench for pc_stack: a queue-based reference model predicts
// PCout/depth/ovf/unf after every edge; a negedge monitor compares.
module tb_pc_stack;

    logic       clk;
    logic       reset;
    logic       stall;
    logic [2:0] op;
    logic [5:0] Branchaddr;
    logic [5:0] PCout;
    logic [2:0] depth;
    logic       ovf;
    logic       unf;

    pc_stack #(.Psize(6), .Sdepth(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .op        (op),
        .Branchaddr(Branchaddr),
        .PCout     (PCout),
        .depth     (depth),
        .ovf       (ovf),
        .unf       (unf)
    );

    typedef struct {
        int pc;
        int dep;
        int ov;
        int un;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // reference model state
    int m_pc;
    int m_ov;
    int m_un;
    int m_stk[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        m_pc = 0;
        m_ov = 0;
        m_un = 0;
        m_stk.delete();
    endfunction

    function automatic void model_exec(int s, int o, int b);
        int sb;
        if (s != 0) return;
        case (o)
            1: m_pc = (m_pc + 1) % 64;
            2: begin
                sb = (b >= 32) ? b - 64 : b;
                m_pc = (m_pc + sb + 1) & 63;
            end
            3: m_pc = b;
            4: begin
                if (m_stk.size() < 4) begin
                    m_stk.push_back((m_pc + 1) % 64);
                    m_pc = b;
                end else begin
                    m_ov = 1;
                    m_pc = (m_pc + 1) % 64;
                end
            end
            5: begin
                if (m_stk.size() > 0) begin
                    m_pc = m_stk.pop_back();
                end else begin
                    m_un = 1;
                    m_pc = (m_pc + 1) % 64;
                end
            end
            default: ;
        endcase
    endfunction

    function automatic void push_exp();
        exp_t e;
        e.pc  = m_pc;
        e.dep = m_stk.size();
        e.ov  = m_ov;
        e.un  = m_un;
        q.push_back(e);
    endfunction

    task automatic step(input int s, input int o, input int b);
        stall      = s[0];
        op         = o[2:0];
        Branchaddr = b[5:0];
        @(posedge clk);
        #1;
        if (reset) model_reset();
        else model_exec(s, o, b);
        push_exp();
    endtask

    // Execute one op, then assert reset mid-cycle; the monitor sees the
    // reset values at the following negedge with no clock edge between.
    task automatic step_rst(input int s, input int o, input int b);
        stall      = s[0];
        op         = o[2:0];
        Branchaddr = b[5:0];
        @(posedge clk);
        #1;
        model_exec(s, o, b);
        #1;
        reset = 1'b1;
        model_reset();
        push_exp();
        @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("PCout", int'(PCout), e.pc);
                chk("depth", int'(depth), e.dep);
                chk("ovf", int'(ovf), e.ov);
                chk("unf", int'(unf), e.un);
            end
        end
    end

    initial begin : driver
        int o;
        int s;
        int wait_cyc;
        reset      = 1'b1;
        stall      = 1'b0;
        op         = 3'b000;
        Branchaddr = 6'd0;
        model_reset();
        step(0, 1, 0);
        step(0, 1, 0);
        reset = 1'b0;

        // increment and wrap
        step(0, 1, 0);
        step(0, 1, 0);
        step(0, 1, 0);
        step(0, 3, 63);
        step(0, 1, 0);
        // relative branches
        step(0, 3, 10);
        step(0, 2, 6'b111100);
        step(0, 3, 60);
        step(0, 2, 5);
        // simple call/return
        step(0, 3, 5);
        step(0, 4, 20);
        step(0, 5, 0);
        // nested calls, overflow, unwinding
        step(0, 3, 1);
        step(0, 4, 10);
        step(0, 3, 11);
        step(0, 4, 20);
        step(0, 3, 21);
        step(0, 4, 30);
        step(0, 3, 31);
        step(0, 4, 40);
        step(0, 4, 50);
        for (int i = 0; i < 4; i++) step(0, 5, 0);
        // underflow, sticky through later ops
        step(0, 3, 9);
        step(0, 5, 0);
        step(0, 1, 0);
        step(0, 4, 33);
        step(0, 5, 0);
        // stall blocks a call
        step(1, 4, 44);
        step(1, 5, 0);
        step(0, 0, 0);
        step(0, 7, 12);
        // reset with depth 3
        step(0, 4, 3);
        step(0, 4, 4);
        step_rst(0, 4, 5);
        step(0, 5, 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            s = ($urandom_range(0, 7) == 0) ? 1 : 0;
            o = $urandom_range(0, 7);
            if ($urandom_range(0, 59) == 0)
                step_rst(s, o, $urandom_range(0, 63));
            else
                step(s, o, $urandom_range(0, 63));
        end

        wait_cyc = 0;
        while (q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
